// File: rtl/keyword_tokenizer_pkg.sv
// Shared encodings for the keyword tokenizer and the downstream nesting checker.
package keyword_tokenizer_pkg;

  typedef enum logic [1:0] {
    TOK_OTHER = 2'd0,
    TOK_BEGIN = 2'd1,
    TOK_END   = 2'd2
  } tok_type_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_B1,
    S_B2,
    S_B3,
    S_B4,
    S_BFULL,
    S_E1,
    S_E2,
    S_EFULL,
    S_OTH
  } state_e;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  // Keyword state advance on one lower-cased word character.
  function automatic state_e next_state(input state_e s, input logic [7:0] c);
    state_e n;
    n = S_OTH;
    case (s)
      S_IDLE: n = (c == 8'h62) ? S_B1 : (c == 8'h65) ? S_E1 : S_OTH;
      S_B1:   n = (c == 8'h65) ? S_B2    : S_OTH;
      S_B2:   n = (c == 8'h67) ? S_B3    : S_OTH;
      S_B3:   n = (c == 8'h69) ? S_B4    : S_OTH;
      S_B4:   n = (c == 8'h6E) ? S_BFULL : S_OTH;
      S_E1:   n = (c == 8'h6E) ? S_E2    : S_OTH;
      S_E2:   n = (c == 8'h64) ? S_EFULL : S_OTH;
      default: n = S_OTH;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/keyword_tokenizer_char_classify.sv
// Combinational delimiter detection and ASCII lower-casing for keyword matching.
module char_classify
  import keyword_tokenizer_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_is_delim,
  output logic [7:0] o_lower
);

  always_comb begin
    o_is_delim = (i_char == CH_SPACE) || (i_char == CH_TAB) ||
                 (i_char == CH_LF)    || (i_char == CH_CR);
    o_lower    = i_char;
    if (i_char >= 8'h41 && i_char <= 8'h5A) o_lower = i_char + 8'h20;
  end

endmodule

// File: rtl/keyword_tokenizer.sv
// Splits an ASCII stream into whitespace-delimited words and emits one
// classified (BEGIN/END/OTHER) token per word with length and running count.
module keyword_tokenizer
  import keyword_tokenizer_pkg::*;
#(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  input  logic             in_valid,
  input  logic             eos,
  output logic             tok_valid,
  output logic [1:0]       tok_type,
  output logic [LEN_W-1:0] tok_len,
  output logic [CNT_W-1:0] tok_count,
  output logic             busy
);

  logic             w_is_delim;
  logic [7:0]       w_lower;
  logic             w_char;
  logic             w_delim;
  state_e           w_state_after;
  logic [LEN_W-1:0] w_len_after;
  logic             w_emit;

  state_e           r_state;
  logic [LEN_W-1:0] r_len;
  logic             r_tok_valid;
  tok_type_e        r_tok_type;
  logic [LEN_W-1:0] r_tok_len;
  logic [CNT_W-1:0] r_tok_count;
  logic             r_busy;

  char_classify u_classify (
    .i_char     (in),
    .o_is_delim (w_is_delim),
    .o_lower    (w_lower)
  );

  // The current character is folded in first, so eos on the same cycle
  // emits a word that includes it.
  always_comb begin
    w_char        = in_valid && !w_is_delim;
    w_delim       = in_valid && w_is_delim;
    w_state_after = r_state;
    w_len_after   = r_len;
    if (w_char) begin
      w_state_after = next_state(r_state, w_lower);
      if (r_state == S_IDLE)  w_len_after = LEN_W'(1);
      else if (r_len != '1)   w_len_after = r_len + LEN_W'(1);
    end
    w_emit = (w_delim || eos) && (w_state_after != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_tok_valid <= 1'b0;
      r_tok_type  <= TOK_OTHER;
      r_tok_len   <= '0;
      r_tok_count <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_tok_valid <= w_emit;
      r_len       <= w_len_after;
      if (w_emit || w_delim) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_after;
        r_busy  <= (w_state_after != S_IDLE);
      end
      if (w_emit) begin
        r_tok_len   <= w_len_after;
        r_tok_count <= r_tok_count + CNT_W'(1);
        case (w_state_after)
          S_BFULL: r_tok_type <= TOK_BEGIN;
          S_EFULL: r_tok_type <= TOK_END;
          default: r_tok_type <= TOK_OTHER;
        endcase
      end
    end
  end

  assign tok_valid = r_tok_valid;
  assign tok_type  = r_tok_type;
  assign tok_len   = r_tok_len;
  assign tok_count = r_tok_count;
  assign busy      = r_busy;

endmodule

// File: tb/tb_keyword_tokenizer.sv
// Self-checking bench: directed scenarios plus random traffic compared every
// cycle against a word-buffer reference model.
module tb_keyword_tokenizer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in = 8'h00;
  logic        in_valid = 1'b0;
  logic        eos = 1'b0;
  logic        tok_valid;
  logic [1:0]  tok_type;
  logic [7:0]  tok_len;
  logic [15:0] tok_count;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: buffered word (lower-cased) and expected registered outputs.
  byte unsigned m_word[$];
  logic        m_valid = 1'b0;
  logic [1:0]  m_type = 2'd0;
  logic [7:0]  m_len = 8'd0;
  logic [15:0] m_count = 16'd0;

  keyword_tokenizer #(.LEN_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .eos       (eos),
    .tok_valid (tok_valid),
    .tok_type  (tok_type),
    .tok_len   (tok_len),
    .tok_count (tok_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_ws(input logic [7:0] c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
  endfunction

  function automatic byte unsigned lc(input logic [7:0] c);
    return (c >= "A" && c <= "Z") ? byte'(c + 8'd32) : byte'(c);
  endfunction

  function automatic bit word_is(input string kw);
    if (m_word.size() != kw.len()) return 1'b0;
    for (int i = 0; i < kw.len(); i++)
      if (m_word[i] != kw[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_emit();
    m_valid = 1'b1;
    m_type  = word_is("begin") ? 2'd1 : word_is("end") ? 2'd2 : 2'd0;
    m_len   = (m_word.size() > 255) ? 8'd255 : 8'(m_word.size());
    m_count = m_count + 16'd1;
    m_word.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] c, input logic e);
    m_valid = 1'b0;
    if (v) begin
      if (is_ws(c)) begin
        if (m_word.size() > 0) model_emit();
      end else begin
        m_word.push_back(lc(c));
      end
    end
    if (e && m_word.size() > 0) model_emit();
  endtask

  task automatic compare_all();
    check("tok_valid", 32'(tok_valid), 32'(m_valid));
    check("tok_type",  32'(tok_type),  32'(m_type));
    check("tok_len",   32'(tok_len),   32'(m_len));
    check("tok_count", 32'(tok_count), 32'(m_count));
    check("busy",      32'(busy),      32'(m_word.size() > 0));
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic e);
    @(negedge clk);
    in_valid = v;
    in       = c;
    eos      = e;
    @(posedge clk);
    model_step(v, c, e);
    #1;
    compare_all();
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] ch;
      ch = s[i];
      step(1'b1, ch, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    eos      = 1'b0;
    #1;
    m_word.delete();
    m_valid = 1'b0;
    m_type  = 2'd0;
    m_len   = 8'd0;
    m_count = 16'd0;
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    byte unsigned alphabet[16];
    alphabet = '{"b", "B", "e", "E", "g", "G", "i", "I", "n", "N", "d", "D",
                 "x", 8'h20, 8'h09, 8'h0A};

    do_reset();

    send_str("begin end ");
    step(1'b0, 8'h00, 1'b0);
    check("cnt_after_begin_end", 32'(tok_count), 32'd2);

    send_str("BeGiN  \t\nEnD");
    step(1'b0, 8'h00, 1'b1);
    check("end_on_eos_type", 32'(tok_type), 32'd2);
    step(1'b0, 8'h00, 1'b1);

    send_str("beg beginx ends e ");

    for (int i = 0; i < 300; i++) step(1'b1, "a", 1'b0);
    step(1'b1, 8'h20, 1'b0);
    check("long_word_len", 32'(tok_len), 32'd255);

    send_str("begi");
    do_reset();
    check("busy_after_reset", 32'(busy), 32'd0);
    send_str("end ");
    step(1'b0, 8'h00, 1'b0);
    check("cnt_after_reset", 32'(tok_count), 32'd1);

    step(1'b1, "b", 1'b0); step(1'b0, 8'h00, 1'b0);
    step(1'b1, "e", 1'b0); step(1'b0, 8'h00, 1'b0); step(1'b0, 8'h00, 1'b0);
    step(1'b1, "g", 1'b0); step(1'b0, 8'h00, 1'b0);
    step(1'b1, "i", 1'b0);
    step(1'b1, "n", 1'b0); step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    check("gapped_begin_type", 32'(tok_type), 32'd1);
    check("gapped_begin_len",  32'(tok_len),  32'd5);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        logic [7:0] ch;
        ch = alphabet[$urandom_range(0, 15)];
        step($urandom_range(0, 3) != 0, ch, $urandom_range(0, 15) == 0);
      end
    end

    // One-character word terminated by eos yields a token every cycle.
    do_reset();
    for (int i = 0; i < 65535; i++) step(1'b1, "a", 1'b1);
    check("cnt_at_max", 32'(tok_count), 32'hFFFF);
    send_str("z ");
    check("cnt_wrap", 32'(tok_count), 32'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keyword_tokenizer.md
# keyword_tokenizer

- Upstream front-end of the block-nesting checker.
- Consumes a raw 8-bit ASCII character stream, one optional character per cycle, and splits it into whitespace-delimited words.
- Classifies each word case-insensitively as BEGIN, END or OTHER and emits one registered token pulse per word, with word length and a running token count.
- The nesting stage therefore sees only classified tokens, never raw characters.

## Interface
- LEN_W, 8: width of tok_len; length saturates at 2^LEN_W-1.
- CNT_W, 16: width of tok_count; wraps modulo 2^CNT_W.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- in  input  8  ASCII character, sampled only when in_valid=1.
- in_valid  input  1  in carries a character this cycle.
- eos  input  1  end-of-stream; flushes a pending word without a trailing delimiter.
- tok_valid  output  1  one-cycle pulse: a token is present on tok_type/tok_len.
- tok_type  output  2  0=OTHER, 1=BEGIN, 2=END; 3 never driven.
- tok_len  output  LEN_W  character count of the emitted word.
- tok_count  output  CNT_W  total tokens emitted since reset.
- busy  output  1  high while a word is partially accumulated.

## Operation
- Delimiters: 0x20 space, 0x09 tab, 0x0A LF, 0x0D CR. Every other byte, including punctuation and digits, is a word character.
- Case folding: bytes 0x41–0x5A compare equal to 0x61–0x7A; folding applies to matching only.
- FSM states:
  - IDLE: between words.
  - B1, B2, B3, B4: prefix "b", "be", "beg", "begi" matched.
  - BFULL: "begin" matched.
  - E1, E2: prefix "e", "en" matched.
  - EFULL: "end" matched.
  - OTH: word is not a keyword.
- Transitions on in_valid=1 with a word character:
  - IDLE→B1 on b/B; IDLE→E1 on e/E; IDLE→OTH otherwise.
  - Each prefix state advances on the next expected letter, otherwise →OTH.
  - B4→BFULL on n/N; E2→EFULL on d/D.
  - BFULL, EFULL and OTH go →OTH on any further word character, so "beginx" and "ends" are OTHER.
- Delimiter from IDLE: stays IDLE, no token; runs of delimiters collapse.
- Delimiter from any other state: emit token, →IDLE.
  - tok_type = BEGIN if state is BFULL, END if EFULL, OTHER otherwise; partial prefixes such as "beg" are OTHER.
- Length counter: cleared when entering a word; +1 per word character; saturates at 2^LEN_W-1.
- in_valid=0: state and length hold; eos still acts.
- eos in the same cycle as a valid character: the character is consumed first. If the resulting state is not IDLE, emit the token, including that character, and go →IDLE.
- eos with no pending word: no token.
- At most one token per cycle; each emission increments tok_count by 1, wrapping.

## Timing
- Latency: token outputs update on the rising edge that samples the terminating delimiter or eos. They are visible the following cycle, one cycle after the delimiter is presented.
- tok_valid is high for exactly one cycle per token. tok_type and tok_len hold their last values when tok_valid=0.
- Back-to-back words separated by a single delimiter give tok_valid pulses as close as every other cycle, one word character plus one delimiter.
- busy is registered: high the cycle after the first word character is sampled, low the cycle after the emitting edge.
- Reset values: tok_valid=0, tok_type=0, tok_len=0, tok_count=0, busy=0, FSM=IDLE, length=0.
- Reset asserted mid-word discards the partial word; no token is emitted after release.
- No input backpressure; every cycle's in_valid character is consumed.

## Structure
- Shared package or header holds:
  - token-type encodings TOK_OTHER, TOK_BEGIN, TOK_END;
  - FSM state encodings;
  - delimiter byte constants.
- The nesting checker reuses the token encodings.
- One natural sub-module, char_classify: combinational is_delim and lower-cased character. Everything else lives in the top module.

## Test plan
- "begin end " presented continuously with in_valid=1:
  - tokens (1,5) then (2,3);
  - tok_count=2;
  - each tok_valid is high one cycle after the corresponding space.
- "BeGiN  \t\nEnD" then eos on the cycle after 'D':
  - BEGIN len 5;
  - the delimiter run yields no extra token;
  - END len 3 emitted on the eos edge.
- "beg beginx ends e " → four OTHER tokens with lengths 3, 6, 4, 1.
- A 300-character word of 'a' then a space → single OTHER token, tok_len=255.
- Reset pulsed after "begi" → no token, busy=0; then "end " → END len 3, tok_count=1.
- Force tok_count to 0xFFFF by emitting 65535 tokens, then one more word → tok_count=0x0000.
- in_valid gaps inside "be_g_in " (in_valid=0 cycles between characters) → BEGIN len 5.
